// File: rtl/ahb_slave_port_arbiter_if.sv
// Bus bundle between the master request lines and one slave-port arbiter.
// The master modport drives requests; the slave modport is the arbiter side.
interface ahb_slave_port_arbiter_if #(
   parameter int unsigned MASTER_NUM = 4,
   parameter int unsigned ID_W       = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
);
   logic [MASTER_NUM-1:0]      hreq;
   logic [MASTER_NUM-1:0][2:0] hburst;
   logic                       hwait;
   logic                       rr_mode;
   logic [MASTER_NUM-1:0]      hgrant;
   logic                       hsel;
   logic [ID_W-1:0]            hmaster_id;
   logic                       hlast;

   modport master (
      output hreq, hburst, hwait, rr_mode,
      input  hgrant, hsel, hmaster_id, hlast
   );

   modport slave (
      input  hreq, hburst, hwait, rr_mode,
      output hgrant, hsel, hmaster_id, hlast
   );
endinterface

// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave AHB arbiter: fixed-priority or round-robin selection among MASTER_NUM
// masters, grant held for a whole burst and handed over without an idle cycle.
// Optional feature macro: AHB_ARB_INCR_CAP_EN (caps undefined-length INCR bursts at
// INCR_MAX_BEATS beats when another master is waiting).
module ahb_slave_port_arbiter #(
   parameter int unsigned MASTER_NUM     = 4,
   parameter int unsigned ID_W           = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
   parameter int unsigned INCR_MAX_BEATS = 16
) (
   input logic                      hclk,
   input logic                      hreset_n,
   ahb_slave_port_arbiter_if.slave  bus
);

`ifdef AHB_ARB_INCR_CAP_EN
   localparam bit IncrCapEn = 1'b1;
`else
   localparam bit IncrCapEn = 1'b0;
`endif

   localparam logic [2:0] BurstIncr = 3'd1;

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e                state_q;
   logic [MASTER_NUM-1:0] grant_q;
   logic                  hsel_q;
   logic [ID_W-1:0]       owner_q;
   logic [2:0]            burst_q;
   logic [4:0]            beat_cnt_q;
   logic [ID_W-1:0]       rr_ptr_q;

   logic                  arb_found;
   logic [ID_W-1:0]       arb_idx;
   logic [ID_W-1:0]       start_idx;
   logic [ID_W-1:0]       next_ptr;
   logic [4:0]            total_m1;
   logic                  owner_req;
   logic                  others_req;
   logic                  cap_hit;
   logic                  burst_end;
   logic                  hlast;
   logic                  end_beat;

   // Beat count minus one for fixed-length bursts
   always_comb begin
      total_m1 = 5'd0;
      case (burst_q)
         3'd2, 3'd3: total_m1 = 5'd3;
         3'd4, 3'd5: total_m1 = 5'd7;
         3'd6, 3'd7: total_m1 = 5'd15;
         default:    total_m1 = 5'd0;
      endcase
   end

   // Burst end detection and combinational last-beat flag
   always_comb begin
      next_ptr   = ID_W'((32'(owner_q) + 32'd1) % MASTER_NUM);
      owner_req  = bus.hreq[owner_q];
      others_req = |(bus.hreq & ~grant_q);
      cap_hit    = (32'(beat_cnt_q) == (INCR_MAX_BEATS - 32'd1));
      if (burst_q == BurstIncr) begin
         burst_end = ~owner_req | (IncrCapEn & cap_hit & others_req);
      end else begin
         burst_end = (beat_cnt_q == total_m1);
      end
      hlast    = (state_q == StOwn) & burst_end;
      end_beat = hlast & ~bus.hwait;
   end

   // Arbitration: circular search from start_idx; fixed priority starts at 0.
   // At a burst end the search starts just past the owner, i.e. at the value rr_ptr
   // is about to take, so the owner wins again only when nobody else asks.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      arb_found = 1'b0;
      arb_idx   = '0;
      if (!bus.rr_mode) begin
         start_idx = '0;
      end else if (state_q == StOwn) begin
         start_idx = next_ptr;
      end else begin
         start_idx = rr_ptr_q;
      end
      for (int i = 0; i < int'(MASTER_NUM); i++) begin
         idx = (32'(start_idx) + 32'(i)) % MASTER_NUM;
         if (!arb_found && bus.hreq[idx]) begin
            arb_found = 1'b1;
            arb_idx   = ID_W'(idx);
         end
      end
   end

   // Ownership FSM with registered grant, select and master id
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         hsel_q     <= 1'b0;
         owner_q    <= '0;
         burst_q    <= 3'd0;
         beat_cnt_q <= 5'd0;
         rr_ptr_q   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (arb_found) begin
                  state_q    <= StOwn;
                  grant_q    <= {{(MASTER_NUM-1){1'b0}}, 1'b1} << arb_idx;
                  hsel_q     <= 1'b1;
                  owner_q    <= arb_idx;
                  burst_q    <= bus.hburst[arb_idx];
                  beat_cnt_q <= 5'd0;
               end
            end
            StOwn: begin
               if (end_beat) begin
                  rr_ptr_q <= next_ptr;
                  if (arb_found) begin
                     grant_q    <= {{(MASTER_NUM-1){1'b0}}, 1'b1} << arb_idx;
                     hsel_q     <= 1'b1;
                     owner_q    <= arb_idx;
                     burst_q    <= bus.hburst[arb_idx];
                     beat_cnt_q <= 5'd0;
                  end else begin
                     state_q    <= StIdle;
                     grant_q    <= '0;
                     hsel_q     <= 1'b0;
                     owner_q    <= '0;
                     burst_q    <= 3'd0;
                     beat_cnt_q <= 5'd0;
                  end
               end else if (!bus.hwait) begin
                  beat_cnt_q <= beat_cnt_q + 5'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.hgrant     = grant_q;
   assign bus.hsel       = hsel_q;
   assign bus.hmaster_id = owner_q;
   assign bus.hlast      = hlast;

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed bench for ahb_slave_port_arbiter (4 masters).
module tb_ahb_slave_port_arbiter;

   logic hclk;
   logic hreset_n;
   int   vectors;
   int   miscompares;

   ahb_slave_port_arbiter_if #(.MASTER_NUM(4)) bus ();

   ahb_slave_port_arbiter #(
      .MASTER_NUM     (4),
      .INCR_MAX_BEATS (16)
   ) dut (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .bus      (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] wait_pat;
      vectors      = 0;
      miscompares  = 0;
      hreset_n     = 1'b0;
      bus.hreq     = '0;
      bus.hburst   = '0;
      bus.hwait    = 1'b0;
      bus.rr_mode  = 1'b0;

      // Reset state
      tick();
      chk("rst_grant", 32'(bus.hgrant), 32'h0);
      chk("rst_hsel", 32'(bus.hsel), 32'h0);
      chk("rst_id", 32'(bus.hmaster_id), 32'h0);
      chk("rst_hlast", 32'(bus.hlast), 32'h0);
      hreset_n = 1'b1;

      // Fixed priority, two SINGLE requesters
      bus.rr_mode = 1'b0;
      bus.hreq    = 4'b1010;
      #1;
      chk("fp_idle_grant", 32'(bus.hgrant), 32'h0);
      tick();
      chk("fp_grant_m1", 32'(bus.hgrant), 32'h2);
      chk("fp_id_m1", 32'(bus.hmaster_id), 32'h1);
      chk("fp_hlast_m1", 32'(bus.hlast), 32'h1);
      bus.hreq = 4'b1000;
      tick();
      chk("fp_grant_m3", 32'(bus.hgrant), 32'h8);
      chk("fp_id_m3", 32'(bus.hmaster_id), 32'h3);
      bus.hreq = 4'b0000;
      tick();
      chk("fp_idle_grant2", 32'(bus.hgrant), 32'h0);
      chk("fp_idle_hsel", 32'(bus.hsel), 32'h0);
      chk("fp_idle_id", 32'(bus.hmaster_id), 32'h0);

      // Round-robin, all SINGLE, no gaps
      bus.rr_mode = 1'b1;
      bus.hreq    = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("rr_id_%0d", k), 32'(bus.hmaster_id), 32'(k % 4));
         chk($sformatf("rr_hsel_%0d", k), 32'(bus.hsel), 32'h1);
      end
      bus.hreq = 4'b0000;
      tick();
      chk("rr_idle_grant", 32'(bus.hgrant), 32'h0);

      // INCR4 with wait states on beats 1 and 2; owner drops request early
      bus.rr_mode   = 1'b0;
      bus.hburst[0] = 3'd3;
      bus.hreq      = 4'b0001;
      wait_pat      = 6'b000101;
      tick();
      for (int c = 0; c < 6; c++) begin
         bus.hreq  = 4'b0000;
         bus.hwait = wait_pat[c];
         #1;
         chk($sformatf("ws_grant_%0d", c), 32'(bus.hgrant), 32'h1);
         chk($sformatf("ws_hlast_%0d", c), 32'(bus.hlast), (c == 5) ? 32'h1 : 32'h0);
         tick();
      end
      bus.hwait = 1'b0;
      chk("ws_release", 32'(bus.hgrant), 32'h0);

      // INCR held by m1 while m2 waits
      bus.rr_mode   = 1'b1;
      bus.hburst    = '0;
      bus.hburst[1] = 3'd1;
      bus.hreq      = 4'b0110;
      tick();
`ifdef AHB_ARB_INCR_CAP_EN
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("incr_grant_%0d", c), 32'(bus.hgrant), 32'h2);
         chk($sformatf("incr_hlast_%0d", c), 32'(bus.hlast), (c == 15) ? 32'h1 : 32'h0);
         tick();
      end
`else
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("incr_grant_%0d", c), 32'(bus.hgrant), 32'h2);
         chk($sformatf("incr_hlast_%0d", c), 32'(bus.hlast), 32'h0);
         tick();
      end
      bus.hreq = 4'b0100;
      #1;
      chk("incr_hlast_drop", 32'(bus.hlast), 32'h1);
      tick();
`endif
      chk("incr_grant_m2", 32'(bus.hgrant), 32'h4);
      chk("incr_id_m2", 32'(bus.hmaster_id), 32'h2);
      bus.hreq = 4'b0000;
      tick();
      chk("incr_idle", 32'(bus.hgrant), 32'h0);

      // INCR8 where owner drops request after beat 2
      bus.rr_mode   = 1'b0;
      bus.hburst    = '0;
      bus.hburst[0] = 3'd5;
      bus.hreq      = 4'b0001;
      tick();
      for (int c = 0; c < 8; c++) begin
         if (c == 2) bus.hreq = 4'b0000;
         #1;
         chk($sformatf("drop_grant_%0d", c), 32'(bus.hgrant), 32'h1);
         chk($sformatf("drop_hlast_%0d", c), 32'(bus.hlast), (c == 7) ? 32'h1 : 32'h0);
         tick();
      end
      chk("drop_release", 32'(bus.hgrant), 32'h0);

      // Asynchronous reset in beat 3 of an INCR8
      bus.hreq = 4'b0001;
      tick();
      tick();
      tick();
      chk("ar_pre_grant", 32'(bus.hgrant), 32'h1);
      hreset_n = 1'b0;
      #1;
      chk("ar_grant", 32'(bus.hgrant), 32'h0);
      chk("ar_hsel", 32'(bus.hsel), 32'h0);
      chk("ar_id", 32'(bus.hmaster_id), 32'h0);
      bus.hreq = 4'b0000;
      tick();
      hreset_n = 1'b1;
      tick();
      tick();
      chk("ar_after_grant", 32'(bus.hgrant), 32'h0);
      chk("ar_after_hsel", 32'(bus.hsel), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
